// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle datapath with a unified, handshaked memory.
// Moore-style sequencing; only FETCH (mem_ready) and BRANCH (zero) gate outputs on inputs.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       pc_src,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_q;
  state_t state_nxt;
  logic   illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      illegal_q <= illegal_q | (state_nxt == S_TRAP);
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_nxt = S_EXEC_R;
          OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:          state_nxt = S_BRANCH;
          default:            state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_nxt = S_ALU_WB;
      S_ALU_WB:   state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b10;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB:   reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
    // Architectural write strobes are suppressed for as long as reset is asserted.
    if (!rst_n) begin
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a queue-based instruction model predicts
// every cycle's outputs; a negedge monitor compares DUT outputs against the queue.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic       mem_to_reg, alu_src_a, pc_src, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [17:0] expq[$];

  // Reference model: current step plus a queue of the remaining steps of this instruction.
  int   m_st = 0;
  int   m_plan[$];
  logic m_ill = 1'b0;

  function automatic logic [17:0] exp_vec(int st, logic rdy, logic z, logic rn, logic ill);
    logic pw, iw, mr, mw, io, rw, mtr, asa, ps;
    logic [1:0] asb, aop;
    {pw, iw, mr, mw, io, rw, mtr, asa, ps} = 9'b0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0: begin mr = 1; asb = 2'b01; iw = rdy; pw = rdy; end
      1: asb = 2'b10;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; mtr = 1; end
      5: begin mw = 1; io = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: rw = 1;
      8: begin asa = 1; aop = 2'b01; ps = 1; pw = z; end
      default: ;
    endcase
    if (!rn) begin mw = 0; rw = 0; end
    return {4'(st), pw, iw, mr, mw, io, rw, mtr, asa, ps, asb, aop, ill};
  endfunction

  function automatic void model_advance(logic rn, logic rdy, logic [6:0] op);
    if (!rn) begin
      m_st = 0;
      m_plan.delete();
      m_ill = 1'b0;
      return;
    end
    case (m_st)
      0: if (rdy) m_st = 1;
      1: begin
        m_plan.delete();
        if (op == 7'b0110011)      m_plan = '{6, 7};
        else if (op == 7'b0000011) m_plan = '{2, 3, 4};
        else if (op == 7'b0100011) m_plan = '{2, 5};
        else if (op == 7'b1100011) m_plan = '{8};
        else                       m_plan = '{9};
        m_st = m_plan.pop_front();
      end
      9: m_st = 9;
      default: begin
        if ((m_st == 3 || m_st == 5) && !rdy) m_st = m_st;
        else if (m_plan.size() == 0)          m_st = 0;
        else                                  m_st = m_plan.pop_front();
      end
    endcase
    if (m_st == 9) m_ill = 1'b1;
  endfunction

  task automatic step(input logic rn, input logic [6:0] op, input logic z, input logic rdy);
    @(posedge clk);
    #1;
    rst_n = rn; opcode = op; zero = z; mem_ready = rdy;
    expq.push_back(exp_vec(m_st, rdy, z, rn, m_ill));
    model_advance(rn, rdy, op);
  endtask

  always @(negedge clk) begin
    logic [17:0] act, ex;
    if (expq.size() != 0) begin
      ex  = expq.pop_front();
      act = {state, pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg,
             alu_src_a, pc_src, alu_src_b, alu_op, illegal};
      cyc++;
      n_cmp++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got state=%0d ctl=%b, want state=%0d ctl=%b",
                 cyc, act[17:14], act[13:0], ex[17:14], ex[13:0]);
      end
      n_cmp++;
      if ((mem_read & mem_write) !== 1'b0 || (reg_write & pc_write) !== 1'b0) begin
        n_fail++;
        $display("FAIL exclusive_strobes cycle %0d: got rd/wr=%b%b rw/pw=%b%b, want no overlap",
                 cyc, mem_read, mem_write, reg_write, pc_write);
      end
    end
  end

  localparam logic [6:0] OPR = 7'b0110011, OPL = 7'b0000011, OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011, OPX = 7'b1111111;

  function automatic logic [6:0] pick_op();
    int r = $urandom_range(0, 19);
    if (r == 0) return 7'($urandom_range(0, 127));
    case (r % 4)
      0: return OPR;
      1: return OPL;
      2: return OPS;
      default: return OPB;
    endcase
  endfunction

  initial begin
    logic [6:0] op;
    // Reset, then R-type with memory always ready.
    step(0, OPR, 0, 1);
    step(1, OPR, 0, 1); step(1, OPR, 0, 1); step(1, OPR, 0, 1); step(1, OPR, 0, 1);
    // Load with two wait cycles in MEM_RD.
    step(1, OPL, 0, 1); step(1, OPL, 0, 1); step(1, OPL, 0, 1);
    step(1, OPL, 0, 0); step(1, OPL, 0, 0); step(1, OPL, 0, 1); step(1, OPL, 0, 1);
    // Branch taken, then not taken; mem_ready pulses outside memory states are ignored.
    step(1, OPB, 1, 1); step(1, OPB, 1, 0); step(1, OPB, 1, 1);
    step(1, OPB, 0, 1); step(1, OPB, 0, 1); step(1, OPB, 0, 0);
    // Fetch stall for three cycles, then a store.
    step(1, OPS, 0, 0); step(1, OPS, 0, 0); step(1, OPS, 0, 0); step(1, OPS, 0, 1);
    step(1, OPS, 0, 1); step(1, OPS, 0, 0); step(1, OPS, 0, 1);
    // Store interrupted by reset while waiting in MEM_WR.
    step(1, OPS, 0, 1); step(1, OPS, 0, 1); step(1, OPS, 0, 1);
    step(1, OPS, 0, 0); step(0, OPS, 0, 0); step(1, OPR, 0, 0); step(1, OPR, 0, 0);
    // Illegal opcode: trap held 20 cycles, then a one-edge reset.
    step(1, OPX, 0, 1); step(1, OPX, 0, 1);
    for (int i = 0; i < 20; i++) step(1, OPX, 1'($urandom), 1'($urandom));
    step(0, OPX, 0, 1);
    step(1, OPR, 0, 0);
    // Randomized traffic.
    op = OPR;
    for (int i = 0; i < 3000; i++) begin
      if (m_st == 0) op = pick_op();
      step(($urandom_range(0, 99) >= 2), op, 1'($urandom), ($urandom_range(0, 9) < 7));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
